ex_mem_skid_reg: RTL

//  Parametrised EX->MEM pipeline register with a valid/ready handshake and a 2-entry skid buffer.

---
 rtl/ex_mem_pkg.sv | 25 ++
 rtl/ex_mem_entry.sv | 50 +++++
 rtl/ex_mem_skid_reg.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/ex_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ex_mem_pkg
// Description : Shared constants for the EX->MEM skid register: control-bundle
//               width, control bit positions and occupancy state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package ex_mem_pkg;

    // Control bundle {addermuxsel,regwrite,memwrite,memtoreg,memread,branch}
    localparam int CTRL_W        = 6;
    localparam int CTRL_BRANCH   = 0;
    localparam int CTRL_MEMREAD  = 1;
    localparam int CTRL_MEMTOREG = 2;
    localparam int CTRL_MEMWRITE = 3;
    localparam int CTRL_REGWRITE = 4;
    localparam int CTRL_ADDMUX   = 5;

    // State encoding equals the number of stored entries
    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_TWO   = 2'd2;

endpackage : ex_mem_pkg
`default_nettype wire

// File: rtl/ex_mem_entry.sv
`default_nettype none
// ============================================================================
// Module      : ex_mem_entry
// Description : One EX->MEM payload register (branch target, ALU result,
//               zero flag, store data, rd, control) with a load enable.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_mem_entry #(
    parameter int XLEN   = 64,
    parameter int RA_W   = 5,
    parameter int CTRL_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic [XLEN-1:0]   i_adder_out,
    input  logic [XLEN-1:0]   i_alu_result,
    input  logic              i_zero,
    input  logic [XLEN-1:0]   i_writedata,
    input  logic [RA_W-1:0]   i_rd,
    input  logic [CTRL_W-1:0] i_ctrl,
    output logic [XLEN-1:0]   o_adder_out,
    output logic [XLEN-1:0]   o_alu_result,
    output logic              o_zero,
    output logic [XLEN-1:0]   o_writedata,
    output logic [RA_W-1:0]   o_rd,
    output logic [CTRL_W-1:0] o_ctrl
);

    // Capture the payload when loaded; cleared only by reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            o_adder_out  <= '0;
            o_alu_result <= '0;
            o_zero       <= 1'b0;
            o_writedata  <= '0;
            o_rd         <= '0;
            o_ctrl       <= '0;
        end else if (i_load) begin
            o_adder_out  <= i_adder_out;
            o_alu_result <= i_alu_result;
            o_zero       <= i_zero;
            o_writedata  <= i_writedata;
            o_rd         <= i_rd;
            o_ctrl       <= i_ctrl;
        end
    end

endmodule : ex_mem_entry
`default_nettype wire

// File: rtl/ex_mem_skid_reg.sv
`default_nettype none
// ============================================================================
// Module      : ex_mem_skid_reg
// Description : EX->MEM pipeline register with valid/ready handshake and a
//               2-entry skid buffer. ex_ready is registered so MEM back-pressure
//               never forms a combinational path into EX. Control outputs and
//               the branch qualifier are forced to zero when no entry is held.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_mem_skid_reg #(
    parameter int XLEN   = 64,
    parameter int RA_W   = 5,
    parameter int CTRL_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [XLEN-1:0]   ex_adder_out,
    input  logic [XLEN-1:0]   ex_alu_result,
    input  logic              ex_zero,
    input  logic [XLEN-1:0]   ex_writedata,
    input  logic [RA_W-1:0]   ex_rd,
    input  logic [CTRL_W-1:0] ex_ctrl,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [XLEN-1:0]   mem_adder_out,
    output logic [XLEN-1:0]   mem_alu_result,
    output logic              mem_zero,
    output logic [XLEN-1:0]   mem_writedata,
    output logic [RA_W-1:0]   mem_rd,
    output logic [CTRL_W-1:0] mem_ctrl,
    output logic              mem_pcsrc,
    output logic [1:0]        occupancy
);

    import ex_mem_pkg::*;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              r_ex_ready;
    logic              w_acc;
    logic              w_pop;
    logic              w_head_load;
    logic              w_skid_load;
    logic              w_head_from_skid;

    logic [XLEN-1:0]   w_skid_adder_out;
    logic [XLEN-1:0]   w_skid_alu_result;
    logic              w_skid_zero;
    logic [XLEN-1:0]   w_skid_writedata;
    logic [RA_W-1:0]   w_skid_rd;
    logic [CTRL_W-1:0] w_skid_ctrl;

    logic [XLEN-1:0]   w_head_in_adder_out;
    logic [XLEN-1:0]   w_head_in_alu_result;
    logic              w_head_in_zero;
    logic [XLEN-1:0]   w_head_in_writedata;
    logic [RA_W-1:0]   w_head_in_rd;
    logic [CTRL_W-1:0] w_head_in_ctrl;

    logic [CTRL_W-1:0] w_head_ctrl;

    assign w_acc     = ex_valid & r_ex_ready;
    assign mem_valid = (r_state != OCC_EMPTY);
    assign w_pop     = mem_valid & mem_ready;

    // Next-state and load-enable decode; flush overrides any accept or pop
    always_comb begin
        w_state_nxt      = r_state;
        w_head_load      = 1'b0;
        w_skid_load      = 1'b0;
        w_head_from_skid = 1'b0;
        if (flush) begin
            w_state_nxt = OCC_EMPTY;
        end else begin
            case (r_state)
                OCC_EMPTY: begin
                    if (w_acc) begin
                        w_head_load = 1'b1;
                        w_state_nxt = OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (w_acc && w_pop) begin
                        w_head_load = 1'b1;
                    end else if (w_acc) begin
                        w_skid_load = 1'b1;
                        w_state_nxt = OCC_TWO;
                    end else if (w_pop) begin
                        w_state_nxt = OCC_EMPTY;
                    end
                end
                OCC_TWO: begin
                    // ex_ready is low here, so only a pop can happen
                    if (w_pop) begin
                        w_head_load      = 1'b1;
                        w_head_from_skid = 1'b1;
                        w_state_nxt      = OCC_ONE;
                    end
                end
                default: w_state_nxt = OCC_EMPTY;
            endcase
        end
    end

    // Occupancy state and registered ready (derived from next occupancy)
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= OCC_EMPTY;
            r_ex_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_ex_ready <= (w_state_nxt != OCC_TWO);
        end
    end

    // Head refills from the skid entry when draining, otherwise from EX
    assign w_head_in_adder_out  = w_head_from_skid ? w_skid_adder_out  : ex_adder_out;
    assign w_head_in_alu_result = w_head_from_skid ? w_skid_alu_result : ex_alu_result;
    assign w_head_in_zero       = w_head_from_skid ? w_skid_zero       : ex_zero;
    assign w_head_in_writedata  = w_head_from_skid ? w_skid_writedata  : ex_writedata;
    assign w_head_in_rd         = w_head_from_skid ? w_skid_rd         : ex_rd;
    assign w_head_in_ctrl       = w_head_from_skid ? w_skid_ctrl       : ex_ctrl;

    ex_mem_entry #(
        .XLEN   (XLEN),
        .RA_W   (RA_W),
        .CTRL_W (CTRL_W)
    ) u_head (
        .clk          (clk),
        .reset        (reset),
        .i_load       (w_head_load),
        .i_adder_out  (w_head_in_adder_out),
        .i_alu_result (w_head_in_alu_result),
        .i_zero       (w_head_in_zero),
        .i_writedata  (w_head_in_writedata),
        .i_rd         (w_head_in_rd),
        .i_ctrl       (w_head_in_ctrl),
        .o_adder_out  (mem_adder_out),
        .o_alu_result (mem_alu_result),
        .o_zero       (mem_zero),
        .o_writedata  (mem_writedata),
        .o_rd         (mem_rd),
        .o_ctrl       (w_head_ctrl)
    );

    ex_mem_entry #(
        .XLEN   (XLEN),
        .RA_W   (RA_W),
        .CTRL_W (CTRL_W)
    ) u_skid (
        .clk          (clk),
        .reset        (reset),
        .i_load       (w_skid_load),
        .i_adder_out  (ex_adder_out),
        .i_alu_result (ex_alu_result),
        .i_zero       (ex_zero),
        .i_writedata  (ex_writedata),
        .i_rd         (ex_rd),
        .i_ctrl       (ex_ctrl),
        .o_adder_out  (w_skid_adder_out),
        .o_alu_result (w_skid_alu_result),
        .o_zero       (w_skid_zero),
        .o_writedata  (w_skid_writedata),
        .o_rd         (w_skid_rd),
        .o_ctrl       (w_skid_ctrl)
    );

    // NOP-safe outputs: control and branch qualifier only when an entry is held
    assign mem_ctrl  = mem_valid ? w_head_ctrl : '0;
    assign mem_pcsrc = mem_valid & w_head_ctrl[CTRL_BRANCH] & mem_zero;
    assign ex_ready  = r_ex_ready;
    assign occupancy = r_state;

endmodule : ex_mem_skid_reg
`default_nettype wire
